// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared CU command/response line formats and read-arbiter sizing constants.
// The arb_id field is carried by every command and echoed back by the response.
package cu_read_command_arbiter_pkg;

    localparam int CU_READ_ARB_REQUESTORS      = 4;
    localparam int CU_READ_ARB_MAX_OUTSTANDING = 16;
    // Fixed field width so up to 16 arbitrated streams fit without changing the line format.
    localparam int CU_ARB_ID_BITS              = 4;

    typedef struct packed {
        logic [CU_ARB_ID_BITS-1:0] arb_id;
        logic [7:0]                cu_id;
        logic [5:0]                size;
        logic [47:0]               address;
    } CommandPayload;

    typedef struct packed {
        logic          valid;
        CommandPayload cmd;
    } CommandBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
        logic valid;
    } BufferStatus;

    typedef struct packed {
        logic          valid;
        CommandPayload cmd;
        logic [31:0]   data;
    } ResponseBufferLine;

    function automatic CommandBufferLine stamp_command(
        input CommandBufferLine          line,
        input logic [CU_ARB_ID_BITS-1:0] id
    );
        CommandBufferLine stamped;
        stamped            = line;
        stamped.valid      = 1'b1;
        stamped.cmd.arb_id = id;
        return stamped;
    endfunction

endpackage

// File: rtl/cu_read_command_arbiter_rr_encoder.sv
// Round-robin priority encoder: first set bit of the mask at or after rr_ptr, wrapping.
// Purely combinational so other CU arbiters can reuse it.
module round_robin_priority_encoder #(
    parameter int NUM_REQUESTORS = 4,
    parameter int ID_BITS        = $clog2(NUM_REQUESTORS)
) (
    input  logic [NUM_REQUESTORS-1:0] eligible,
    input  logic [ID_BITS-1:0]        rr_ptr,
    output logic [NUM_REQUESTORS-1:0] grant_onehot,
    output logic [ID_BITS-1:0]        grant_index,
    output logic                      grant_any
);

    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        grant_any    = 1'b0;
        for (int k = 0; k < NUM_REQUESTORS; k++) begin
            if (!grant_any && eligible[(int'(rr_ptr) + k) % NUM_REQUESTORS]) begin
                grant_any = 1'b1;
                grant_index = ID_BITS'((int'(rr_ptr) + k) % NUM_REQUESTORS);
                grant_onehot[(int'(rr_ptr) + k) % NUM_REQUESTORS] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Shares the CU read-command channel among the per-stream command FIFO heads,
// throttled by per-stream outstanding-read credits and downstream almost-full.
module cu_read_command_arbiter
    import cu_read_command_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTORS  = CU_READ_ARB_REQUESTORS,
    parameter int MAX_OUTSTANDING = CU_READ_ARB_MAX_OUTSTANDING,
    parameter int ARB_ID_BITS     = $clog2(NUM_REQUESTORS),
    parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1),
    parameter int TOT_BITS        = $clog2(NUM_REQUESTORS * MAX_OUTSTANDING + 1)
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled_in,
    input  logic [NUM_REQUESTORS-1:0] request_in,
    input  CommandBufferLine          command_in [NUM_REQUESTORS],
    input  BufferStatus               read_buffer_status,
    input  ResponseBufferLine         read_response_in,
    output logic [NUM_REQUESTORS-1:0] grant_out,
    output CommandBufferLine          read_command_out,
    output logic [TOT_BITS-1:0]       outstanding_total,
    output logic                      arbiter_idle,
    output logic                      credit_error
);

    logic                      enabled_q;
    logic [ARB_ID_BITS-1:0]    rr_ptr_q;
    logic [CNT_BITS-1:0]       count_q [NUM_REQUESTORS];
    logic [CNT_BITS-1:0]       count_d [NUM_REQUESTORS];
    logic [TOT_BITS-1:0]       total_d;
    logic                      credit_error_d;
    CommandBufferLine          command_d;

    logic [NUM_REQUESTORS-1:0] eligible;
    logic [NUM_REQUESTORS-1:0] enc_onehot;
    logic [ARB_ID_BITS-1:0]    enc_index;
    logic                      enc_any;
    logic                      grant_valid;

    logic                      resp_valid;
    logic [CU_ARB_ID_BITS-1:0] resp_id;
    logic                      resp_in_range;
    logic [NUM_REQUESTORS-1:0] resp_hit;

    logic                      unused_inputs;
    assign unused_inputs = ^{read_response_in.data, read_response_in.cmd.address,
                             read_response_in.cmd.cu_id, read_response_in.cmd.size,
                             read_buffer_status.full, read_buffer_status.empty,
                             read_buffer_status.valid};

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            eligible[i] = request_in[i] && (count_q[i] < CNT_BITS'(MAX_OUTSTANDING));
        end
    end

    round_robin_priority_encoder #(
        .NUM_REQUESTORS (NUM_REQUESTORS),
        .ID_BITS        (ARB_ID_BITS)
    ) u_rr_encoder (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (enc_onehot),
        .grant_index  (enc_index),
        .grant_any    (enc_any)
    );

    assign grant_valid = enabled_q && !read_buffer_status.alfull && enc_any;
    assign grant_out   = grant_valid ? enc_onehot : '0;

    assign resp_valid    = read_response_in.valid;
    assign resp_id       = read_response_in.cmd.arb_id;
    assign resp_in_range = int'(resp_id) < NUM_REQUESTORS;

    always_comb begin
        resp_hit = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            resp_hit[i] = resp_valid && resp_in_range && (resp_id == CU_ARB_ID_BITS'(i));
        end
    end

    // A response with nothing outstanding means the credit books are wrong; flag it and hold at zero.
    always_comb begin
        credit_error_d = credit_error;
        total_d        = '0;
        if (resp_valid && !resp_in_range) begin
            credit_error_d = 1'b1;
        end
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            count_d[i] = count_q[i];
            if (resp_hit[i] && (count_q[i] == '0)) begin
                credit_error_d = 1'b1;
            end
            if (grant_out[i] && !resp_hit[i]) begin
                count_d[i] = count_q[i] + CNT_BITS'(1);
            end else if (resp_hit[i] && !grant_out[i] && (count_q[i] != '0)) begin
                count_d[i] = count_q[i] - CNT_BITS'(1);
            end
            total_d = total_d + TOT_BITS'(count_d[i]);
        end
    end

    always_comb begin
        command_d = '0;
        if (grant_valid) begin
            command_d = stamp_command(command_in[enc_index], CU_ARB_ID_BITS'(enc_index));
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q         <= 1'b0;
            rr_ptr_q          <= '0;
            read_command_out  <= '0;
            outstanding_total <= '0;
            arbiter_idle      <= 1'b0;
            credit_error      <= 1'b0;
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            enabled_q         <= enabled_in;
            read_command_out  <= command_d;
            outstanding_total <= total_d;
            arbiter_idle      <= (total_d == '0) && !command_d.valid;
            credit_error      <= credit_error_d;
            if (grant_valid) begin
                rr_ptr_q <= ARB_ID_BITS'((int'(enc_index) + 1) % NUM_REQUESTORS);
            end
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed and randomized bench for cu_read_command_arbiter against a credit/round-robin model.
module tb_cu_read_command_arbiter;
    import cu_read_command_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int MAX = 16;

    logic              clock = 1'b0;
    logic              rstn;
    logic              enabled_in;
    logic [N-1:0]      request_in;
    CommandBufferLine  command_in [N];
    BufferStatus       read_buffer_status;
    ResponseBufferLine read_response_in;
    logic [N-1:0]      grant_out;
    CommandBufferLine  read_command_out;
    logic [6:0]        outstanding_total;
    logic              arbiter_idle;
    logic              credit_error;

    cu_read_command_arbiter dut (
        .clock              (clock),
        .rstn               (rstn),
        .enabled_in         (enabled_in),
        .request_in         (request_in),
        .command_in         (command_in),
        .read_buffer_status (read_buffer_status),
        .read_response_in   (read_response_in),
        .grant_out          (grant_out),
        .read_command_out   (read_command_out),
        .outstanding_total  (outstanding_total),
        .arbiter_idle       (arbiter_idle),
        .credit_error       (credit_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_cnt [N];
    int               m_rr;
    bit               m_en_q;
    bit               m_err;
    bit               m_idle;
    int               m_total;
    CommandBufferLine m_cmd;
    int               grants_seen [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0; m_en_q = 0; m_err = 0; m_idle = 0; m_total = 0; m_cmd = '0;
    endtask

    task automatic drive(input logic [N-1:0] req, input bit af, input bit en,
                         input bit rv, input logic [3:0] rid);
        request_in = req;
        read_buffer_status = '0;
        read_buffer_status.alfull = af;
        enabled_in = en;
        read_response_in = '0;
        if (rv) begin
            read_response_in.valid = 1'b1;
            read_response_in.cmd.arb_id = rid;
            read_response_in.data = $urandom;
        end
        for (int i = 0; i < N; i++) begin
            command_in[i] = '0;
            command_in[i].valid = req[i];
            command_in[i].cmd.address = 48'({$urandom, $urandom});
            command_in[i].cmd.size = 6'($urandom);
            command_in[i].cmd.cu_id = 8'($urandom);
            command_in[i].cmd.arb_id = 4'($urandom);
        end
    endtask

    // One clock: check combinational grant, advance model at the edge, check registered outputs.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_vec;
        bit hit;
        g = -1;
        exp_vec = '0;
        if (m_en_q && !read_buffer_status.alfull) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && request_in[(m_rr + k) % N] && m_cnt[(m_rr + k) % N] < MAX)
                    g = (m_rr + k) % N;
            end
        end
        if (g >= 0) exp_vec[g] = 1'b1;
        #1;
        chk("grant_out", 128'(grant_out), 128'(exp_vec));
        for (int i = 0; i < N; i++) grants_seen[i] += int'(grant_out[i]);
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            hit = read_response_in.valid && (int'(read_response_in.cmd.arb_id) == i);
            if (hit && m_cnt[i] == 0) m_err = 1;
            if (g == i && !hit) m_cnt[i]++;
            else if (hit && g != i && m_cnt[i] > 0) m_cnt[i]--;
        end
        if (read_response_in.valid && int'(read_response_in.cmd.arb_id) >= N) m_err = 1;
        m_cmd = '0;
        if (g >= 0) begin
            m_cmd = command_in[g];
            m_cmd.valid = 1'b1;
            m_cmd.cmd.arb_id = 4'(g);
            m_rr = (g + 1) % N;
        end
        m_total = 0;
        for (int i = 0; i < N; i++) m_total += m_cnt[i];
        m_idle = (m_total == 0) && !m_cmd.valid;
        m_en_q = enabled_in;
        #1;
        chk("read_command_out", 128'(read_command_out), 128'(m_cmd));
        chk("outstanding_total", 128'(outstanding_total), 128'(m_total));
        chk("arbiter_idle", 128'(arbiter_idle), 128'(m_idle));
        chk("credit_error", 128'(credit_error), 128'(m_err));
        @(negedge clock);
    endtask

    task automatic run(input logic [N-1:0] req, input bit af, input bit en,
                       input bit rv, input logic [3:0] rid, input int n);
        for (int c = 0; c < n; c++) begin
            drive(req, af, en, rv, rid);
            cycle();
        end
    endtask

    // Asserts reset away from any clock edge and checks outputs clear without a clock.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst grant_out", 128'(grant_out), 128'(0));
        chk("rst read_command_out", 128'(read_command_out), 128'(0));
        chk("rst outstanding_total", 128'(outstanding_total), 128'(0));
        chk("rst arbiter_idle", 128'(arbiter_idle), 128'(0));
        chk("rst credit_error", 128'(credit_error), 128'(0));
        @(negedge clock);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) grants_seen[i] = 0;
    endtask

    initial begin
        rstn = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clock);
        do_reset();

        // Full request set: rotation 0,1,2,3,0 after the enable register fills
        run(4'b1111, 1'b0, 1'b1, 1'b0, 4'd0, 6);
        chk("rotation total", 128'(outstanding_total), 128'(5));

        // Single requester runs out of credits at 16, one response frees one slot
        do_reset();
        run(4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 20);
        chk("credit limit grants", 128'(grants_seen[2]), 128'(16));
        run(4'b0100, 1'b0, 1'b1, 1'b1, 4'd2, 1);
        run(4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 3);
        chk("credit return grants", 128'(grants_seen[2]), 128'(17));

        // Almost-full stalls the channel mid-stream
        do_reset();
        run(4'b0011, 1'b0, 1'b1, 1'b0, 4'd0, 3);
        run(4'b0011, 1'b1, 1'b1, 1'b0, 4'd0, 3);
        run(4'b0011, 1'b0, 1'b1, 1'b0, 4'd0, 3);

        // Grant and response on requester 3 in the same cycle at count 5
        do_reset();
        run(4'b1000, 1'b0, 1'b1, 1'b0, 4'd0, 6);
        run(4'b1000, 1'b0, 1'b1, 1'b1, 4'd3, 1);
        chk("same-cycle total", 128'(outstanding_total), 128'(5));

        // Underflow and out-of-range responses set a sticky error
        run(4'b0000, 1'b0, 1'b1, 1'b1, 4'd1, 1);
        run(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 3);
        run(4'b0000, 1'b0, 1'b1, 1'b1, 4'd9, 1);
        chk("sticky credit_error", 128'(credit_error), 128'(1));

        // Disable with 4 outstanding, drain them, then reset mid-burst
        do_reset();
        run(4'b1111, 1'b0, 1'b1, 1'b0, 4'd0, 4);
        run(4'b1111, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        chk("disable total", 128'(outstanding_total), 128'(4));
        for (int i = 0; i < N; i++) run(4'b1111, 1'b0, 1'b0, 1'b1, 4'(i), 1);
        run(4'b1111, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        chk("drained idle", 128'(arbiter_idle), 128'(1));
        run(4'b1111, 1'b0, 1'b1, 1'b0, 4'd0, 4);
        do_reset();

        // Randomized traffic; responses only for requesters the model shows as in flight
        for (int c = 0; c < 400; c++) begin
            logic [3:0] rid;
            bit rv;
            rid = 4'($urandom_range(0, N - 1));
            rv = ($urandom_range(0, 1) == 1) && (m_cnt[rid] > 0);
            drive(4'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0, rv, rid);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
